// File: rtl/fpu_regfile_csr_if.sv
// fpu_regfile_csr_if: operand, writeback, flag and Zicsr signals of the FP register file / fcsr block.
interface fpu_regfile_csr_if;
  logic [4:0]  rs1Addr_i, rs2Addr_i, rs3Addr_i;
  logic [31:0] rs1_o, rs2_o, rs3_o;
  logic [2:0]  instrRm_i;
  logic [2:0]  rm_o;
  logic        rmIllegal_o;
  logic        wrEnable_i;
  logic [4:0]  wrAddr_i;
  logic [31:0] wrData_i;
  logic        fflagsValid_i;
  logic [4:0]  fflags_i;
  logic        csrEnable_i;
  logic [1:0]  csrOp_i;
  logic [11:0] csrAddr_i;
  logic [31:0] csrWdata_i;
  logic [31:0] csrRdata_o;
  logic        csrIllegal_o;
  logic        fsDirty_o;
  modport slave (
    input  rs1Addr_i, rs2Addr_i, rs3Addr_i, instrRm_i, wrEnable_i, wrAddr_i, wrData_i,
           fflagsValid_i, fflags_i, csrEnable_i, csrOp_i, csrAddr_i, csrWdata_i,
    output rs1_o, rs2_o, rs3_o, rm_o, rmIllegal_o, csrRdata_o, csrIllegal_o, fsDirty_o
  );
  modport master (
    output rs1Addr_i, rs2Addr_i, rs3Addr_i, instrRm_i, wrEnable_i, wrAddr_i, wrData_i,
           fflagsValid_i, fflags_i, csrEnable_i, csrOp_i, csrAddr_i, csrWdata_i,
    input  rs1_o, rs2_o, rs3_o, rm_o, rmIllegal_o, csrRdata_o, csrIllegal_o, fsDirty_o
  );
endinterface

// File: rtl/fpu_regfile_csr.sv
// fpu_regfile_csr: RV32F f-register file plus fcsr (frm, fflags) with Zicsr access and flag accumulation.
// FPU_REG_BYPASS_EN: when defined, reads of the register being written return the write data.
module fpu_regfile_csr #(
  parameter logic [2:0] RESET_FRM = 3'b000
) (
  input logic clk_i,
  input logic reset_i,
  fpu_regfile_csr_if.slave bus
);
`ifdef FPU_REG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic [31:0] regs_q [32];
  logic [2:0]  frm_q, frm_d;
  logic [4:0]  fflags_q, fflags_d;
  logic        dirty_q, dirty_d;
  logic        is_ff, is_rm, legal, upd;
  logic [4:0]  ff_w, ff_res;
  logic [2:0]  rm_w, rm_res;
  logic        unused_wdata;
  function automatic logic [31:0] rd(input logic [4:0] a);
    return (BYP && bus.wrEnable_i && bus.wrAddr_i == a) ? bus.wrData_i : regs_q[a];
  endfunction
  assign bus.rs1_o = rd(bus.rs1Addr_i);
  assign bus.rs2_o = rd(bus.rs2Addr_i);
  assign bus.rs3_o = rd(bus.rs3Addr_i);
  assign bus.rm_o = bus.instrRm_i == 3'b111 ? frm_q : bus.instrRm_i;
  assign bus.rmIllegal_o = bus.rm_o >= 3'b101;
  assign is_ff = bus.csrAddr_i == 12'h001 || bus.csrAddr_i == 12'h003;
  assign is_rm = bus.csrAddr_i == 12'h002 || bus.csrAddr_i == 12'h003;
  assign legal = is_ff || is_rm;
  assign upd = bus.csrEnable_i && legal && bus.csrOp_i != 2'b00;
  assign bus.csrIllegal_o = bus.csrEnable_i && !legal;
  assign bus.csrRdata_o = {24'b0, is_rm ? frm_q : 3'b0, is_ff ? fflags_q : 5'b0} >> (bus.csrAddr_i == 12'h002 ? 5 : 0);
  assign bus.fsDirty_o = dirty_q;
  assign unused_wdata = ^bus.csrWdata_i[31:8];
  // frm sits at bits [2:0] of the frm CSR but at [7:5] of fcsr
  assign ff_w = bus.csrWdata_i[4:0];
  assign rm_w = bus.csrAddr_i == 12'h002 ? bus.csrWdata_i[2:0] : bus.csrWdata_i[7:5];
  always_comb begin
    ff_res = bus.csrOp_i == 2'b01 ? ff_w : bus.csrOp_i == 2'b10 ? fflags_q | ff_w : fflags_q & ~ff_w;
    rm_res = bus.csrOp_i == 2'b01 ? rm_w : bus.csrOp_i == 2'b10 ? frm_q | rm_w : frm_q & ~rm_w;
    fflags_d = (upd && is_ff ? ff_res : fflags_q) | (bus.fflagsValid_i ? bus.fflags_i : 5'b0);
    frm_d = upd && is_rm ? rm_res : frm_q;
    dirty_d = dirty_q || bus.wrEnable_i || upd || (bus.fflagsValid_i && bus.fflags_i != 5'b0);
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      frm_q <= RESET_FRM;
      fflags_q <= '0;
      dirty_q <= 1'b0;
    end else begin
      if (bus.wrEnable_i) regs_q[bus.wrAddr_i] <= bus.wrData_i;
      frm_q <= frm_d;
      fflags_q <= fflags_d;
      dirty_q <= dirty_d;
    end
  end
endmodule

// File: tb/tb_fpu_regfile_csr.sv
// tb_fpu_regfile_csr: table vectors, directed corner sequences and random stimulus against an fcsr/register-array model.
module tb_fpu_regfile_csr;
`ifdef FPU_REG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fpu_regfile_csr_if bus();
  fpu_regfile_csr #(.RESET_FRM(3'b000)) dut (.clk_i(clk), .reset_i(rst), .bus(bus));
  int errs = 0;
  int checks = 0;
  logic [31:0] m_regs [32];
  logic [7:0]  m_fcsr;
  bit          m_dirty;
  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        fv;
    logic [4:0]  fl;
    logic        ill;
    logic [7:0]  fcsr;
  } vec_t;
  vec_t tbl [12];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_fcsr = 8'h00;
    m_dirty = 0;
  endtask
  function automatic logic [31:0] exp_rs(input logic [4:0] a);
    return (BYP && bus.wrEnable_i && bus.wrAddr_i == a) ? bus.wrData_i : m_regs[a];
  endfunction
  function automatic logic [31:0] exp_rdata();
    case (bus.csrAddr_i)
      12'h001: return {27'b0, m_fcsr[4:0]};
      12'h002: return {29'b0, m_fcsr[7:5]};
      12'h003: return {24'b0, m_fcsr};
      default: return 32'b0;
    endcase
  endfunction
  task automatic model_edge();
    int sh, w, fm, old, v, res, f;
    bit legal;
    legal = bus.csrAddr_i >= 1 && bus.csrAddr_i <= 3;
    if (bus.wrEnable_i) begin
      m_regs[bus.wrAddr_i] = bus.wrData_i;
      m_dirty = 1;
    end
    f = m_fcsr;
    if (bus.csrEnable_i && legal && bus.csrOp_i != 0) begin
      sh = bus.csrAddr_i == 2 ? 5 : 0;
      w = bus.csrAddr_i == 1 ? 5 : bus.csrAddr_i == 2 ? 3 : 8;
      fm = (1 << w) - 1;
      old = (f >> sh) & fm;
      v = bus.csrWdata_i & fm;
      res = bus.csrOp_i == 1 ? v : bus.csrOp_i == 2 ? (old | v) : (old & ~v);
      f = (f & ~(fm << sh)) | ((res & fm) << sh);
      m_dirty = 1;
    end
    if (bus.fflagsValid_i) begin
      f = f | bus.fflags_i;
      if (bus.fflags_i != 0) m_dirty = 1;
    end
    m_fcsr = f[7:0];
  endtask
  task automatic check_all();
    logic [2:0] rm;
    #1;
    rm = bus.instrRm_i == 3'b111 ? m_fcsr[7:5] : bus.instrRm_i;
    chk("rs1", bus.rs1_o, exp_rs(bus.rs1Addr_i));
    chk("rs2", bus.rs2_o, exp_rs(bus.rs2Addr_i));
    chk("rs3", bus.rs3_o, exp_rs(bus.rs3Addr_i));
    chk("rm", {29'b0, bus.rm_o}, {29'b0, rm});
    chk("rmIllegal", {31'b0, bus.rmIllegal_o}, {31'b0, rm >= 3'b101});
    chk("csrRdata", bus.csrRdata_o, exp_rdata());
    chk("csrIllegal", {31'b0, bus.csrIllegal_o},
        {31'b0, bus.csrEnable_i && !(bus.csrAddr_i >= 1 && bus.csrAddr_i <= 3)});
    chk("fsDirty", {31'b0, bus.fsDirty_o}, {31'b0, m_dirty});
  endtask
  task automatic cycle();
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask
  task automatic idle();
    bus.wrEnable_i = 0; bus.wrAddr_i = 0; bus.wrData_i = 0;
    bus.fflagsValid_i = 0; bus.fflags_i = 0;
    bus.csrEnable_i = 0; bus.csrOp_i = 0; bus.csrAddr_i = 12'h003; bus.csrWdata_i = 0;
    bus.instrRm_i = 3'b000;
  endtask
  initial begin
    tbl[0]  = '{2'b01, 12'h003, 32'hFFFF_FFE5, 1'b0, 5'h00, 1'b0, 8'hE5};
    tbl[1]  = '{2'b00, 12'h003, 32'h0000_0000, 1'b0, 5'h00, 1'b0, 8'hE5};
    tbl[2]  = '{2'b01, 12'h001, 32'h0000_0000, 1'b0, 5'h00, 1'b0, 8'hE0};
    tbl[3]  = '{2'b01, 12'h002, 32'h0000_0001, 1'b0, 5'h00, 1'b0, 8'h20};
    tbl[4]  = '{2'b10, 12'h002, 32'h0000_0002, 1'b0, 5'h00, 1'b0, 8'h60};
    tbl[5]  = '{2'b00, 12'h001, 32'h0000_0000, 1'b1, 5'h01, 1'b0, 8'h61};
    tbl[6]  = '{2'b00, 12'h001, 32'h0000_0000, 1'b1, 5'h10, 1'b0, 8'h71};
    tbl[7]  = '{2'b11, 12'h001, 32'h0000_0011, 1'b1, 5'h04, 1'b0, 8'h64};
    tbl[8]  = '{2'b01, 12'h004, 32'h0000_00FF, 1'b0, 5'h00, 1'b1, 8'h64};
    tbl[9]  = '{2'b11, 12'h003, 32'h0000_00FF, 1'b0, 5'h00, 1'b0, 8'h00};
    tbl[10] = '{2'b10, 12'h001, 32'hFFFF_FFFF, 1'b0, 5'h00, 1'b0, 8'h1F};
    tbl[11] = '{2'b10, 12'h002, 32'h0000_0007, 1'b1, 5'h00, 1'b0, 8'hFF};
    idle();
    bus.rs1Addr_i = 5; bus.rs2Addr_i = 5; bus.rs3Addr_i = 5;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 0;
    // reset state and dynamic rounding
    bus.instrRm_i = 3'b111;
    #1;
    chk("reset_f5", bus.rs1_o, 32'h0);
    chk("reset_rm", {29'b0, bus.rm_o}, 32'h0);
    chk("reset_rmIllegal", {31'b0, bus.rmIllegal_o}, 32'h0);
    chk("reset_dirty", {31'b0, bus.fsDirty_o}, 32'h0);
    cycle();
    // write f3 and bypass behaviour in the write cycle
    bus.wrEnable_i = 1; bus.wrAddr_i = 3; bus.wrData_i = 32'h3F80_0000;
    bus.rs2Addr_i = 3;
    #1;
    chk("bypass_rs2", bus.rs2_o, BYP ? 32'h3F80_0000 : 32'h0);
    cycle();
    bus.wrEnable_i = 0;
    bus.rs1Addr_i = 3; bus.rs2Addr_i = 3; bus.rs3Addr_i = 3;
    #1;
    chk("readback_rs1", bus.rs1_o, 32'h3F80_0000);
    chk("readback_rs2", bus.rs2_o, 32'h3F80_0000);
    chk("readback_rs3", bus.rs3_o, 32'h3F80_0000);
    chk("dirty_after_write", {31'b0, bus.fsDirty_o}, 32'h1);
    cycle();
    // CSR table
    for (int i = 0; i < 12; i++) begin
      bus.csrEnable_i = 1; bus.csrOp_i = tbl[i].op; bus.csrAddr_i = tbl[i].addr;
      bus.csrWdata_i = tbl[i].wdata; bus.fflagsValid_i = tbl[i].fv; bus.fflags_i = tbl[i].fl;
      #1;
      chk($sformatf("tbl%0d_ill", i), {31'b0, bus.csrIllegal_o}, {31'b0, tbl[i].ill});
      if (tbl[i].ill) chk($sformatf("tbl%0d_rdata0", i), bus.csrRdata_o, 32'h0);
      cycle();
      bus.csrOp_i = 2'b00; bus.csrAddr_i = 12'h003; bus.fflagsValid_i = 0; bus.fflags_i = 0;
      #1;
      chk($sformatf("tbl%0d_fcsr", i), bus.csrRdata_o, {24'b0, tbl[i].fcsr});
    end
    bus.instrRm_i = 3'b111;
    #1;
    chk("dyn_rm_reserved", {31'b0, bus.rmIllegal_o}, 32'h1);
    bus.instrRm_i = 3'b101;
    #1;
    chk("static_rm_101", {31'b0, bus.rmIllegal_o}, 32'h1);
    idle();
    cycle();
    // random stimulus against the model
    for (int n = 0; n < 400; n++) begin
      bus.wrEnable_i = 1'($urandom_range(0, 1));
      bus.wrAddr_i = 5'($urandom);
      bus.wrData_i = $urandom;
      bus.rs1Addr_i = 5'($urandom);
      bus.rs2Addr_i = $urandom_range(0, 1) ? bus.wrAddr_i : 5'($urandom);
      bus.rs3Addr_i = 5'($urandom);
      bus.instrRm_i = 3'($urandom);
      bus.fflagsValid_i = 1'($urandom_range(0, 1));
      bus.fflags_i = 5'($urandom);
      bus.csrEnable_i = 1'($urandom_range(0, 1));
      bus.csrOp_i = 2'($urandom);
      bus.csrAddr_i = 12'($urandom_range(0, 4));
      bus.csrWdata_i = $urandom;
      cycle();
    end
    // asynchronous reset between edges with a write pending
    idle();
    cycle();
    bus.wrEnable_i = 1; bus.wrAddr_i = 7; bus.wrData_i = 32'hDEAD_BEEF;
    bus.rs1Addr_i = 1; bus.rs2Addr_i = 2; bus.rs3Addr_i = 3;
    #2 rst = 1;
    model_reset();
    #1;
    chk("async_dirty", {31'b0, bus.fsDirty_o}, 32'h0);
    chk("async_fcsr", bus.csrRdata_o, 32'h0);
    check_all();
    bus.wrEnable_i = 0;
    #1 rst = 0;
    bus.rs1Addr_i = 7;
    cycle();
    chk("async_write_lost", bus.rs1_o, 32'h0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/fpu_regfile_csr.md
# fpu_regfile_csr

Floating-point architectural state for the RV32F datapath: the 32×32-bit f-register file plus the fcsr (frm, fflags). Sits directly upstream and downstream of the FPU. It supplies rs1/rs2/rs3 operands and the resolved rounding mode to the FPU, captures the FPU result at writeback, and accumulates the FPU exception flags. It also services Zicsr accesses to fflags/frm/fcsr from the integer pipeline.

## Interface

**Parameters**
- RESET_FRM, 3'b000: frm value after reset (RNE).

**Ports**
- clk_i  in  1  core clock; all state updates on the rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- rs1Addr_i / rs2Addr_i / rs3Addr_i  in  5 each  operand register indices.
- rs1_o / rs2_o / rs3_o  out  32 each  operand data, combinational.
- instrRm_i  in  3  funct3 rounding field of the current FP instruction.
- rm_o  out  3  resolved rounding mode, combinational.
- rmIllegal_o  out  1  resolved rounding mode is 101, 110 or 111.
- wrEnable_i  in  1  f-register write strobe.
- wrAddr_i  in  5  destination index.
- wrData_i  in  32  writeback data.
- fflagsValid_i  in  1  FP op retiring this cycle; accumulate its flags.
- fflags_i  in  5  {NV,DZ,OF,UF,NX} from the FPU.
- csrEnable_i  in  1  CSR access this cycle.
- csrOp_i  in  2  00 read-only, 01 write, 10 set, 11 clear.
- csrAddr_i  in  12  CSR address.
- csrWdata_i  in  32  CSR operand (rs1 or uimm, zero-extended).
- csrRdata_o  out  32  old CSR value, combinational.
- csrIllegal_o  out  1  csrEnable_i with an unsupported address.
- fsDirty_o  out  1  FP state modified since reset.

## Operation

**Register file**
- 32 entries. f0 is a normal writable register (no hardwiring).
- Reset clears all entries to 0.
- A write occurs at the clock edge when wrEnable_i is high.
- Reads are asynchronous.

**Rounding-mode resolution**
- rm_o = frm when instrRm_i == 3'b111; otherwise rm_o = instrRm_i.
- rmIllegal_o = (rm_o ≥ 3'b101). This covers a static 101/110 and a dynamic mode with frm ∈ {101, 110, 111}.

**CSR map** (anything else asserts csrIllegal_o, changes no state, and returns csrRdata_o = 0)
- 0x001 fflags: bits[4:0] = fflags; upper bits read 0.
- 0x002 frm: bits[2:0] = frm; upper bits read 0.
- 0x003 fcsr: {24'b0, frm, fflags}. Write bits above 7 are ignored.

**CSR update** (the field is masked to its width)
- Write: new = wdata.
- Set: new = old | wdata.
- Clear: new = old & ~wdata.
- Read-only (op 00): no update.
- frm accepts any 3-bit value, including reserved encodings. Illegality is flagged only at use, via rmIllegal_o.

**Flag accumulation**
- When fflagsValid_i is high: fflags ← fflags | fflags_i.
- Same cycle as a CSR update of fflags/fcsr: fflags ← csrResult | fflags_i. The CSR result is applied first, then the FPU flags are ORed in.

**fsDirty_o**
- Sets on any write-port write, any CSR update that targets a legal address, or fflagsValid_i with fflags_i ≠ 0.
- Clears only on reset.

## Timing

**Reset values**
- All f-registers 0.
- frm = RESET_FRM; fflags = 0; fsDirty_o = 0.
- csrIllegal_o, rmIllegal_o, csrRdata_o, rm_o and rs*_o follow their combinational definitions from the reset state.

**Latency**
- Operands, rm_o and csrRdata_o: 0 cycles (combinational).
- Writes, CSR updates and flag accumulation become visible the cycle after the edge.

**Hazards and ordering**
- Read/write collision on the same index: see Configuration.
- FPU stalls (FPU busy) are handled upstream. This block only sees wrEnable_i and fflagsValid_i in the retire cycle and never back-pressures.
- Reset asserted mid-cycle clears state immediately (asynchronous). Writes presented while reset is high are discarded.

## Configuration

FPU_REG_BYPASS_EN
- Defined: a read whose address equals wrAddr_i while wrEnable_i is high returns wrData_i (write-through). This applies to all three read ports independently.
- Undefined: the read returns the stored (old) value. The pipeline must then insert a one-cycle stall for read-after-write.

## Test plan

- **Reset and dynamic rounding:** reset with RESET_FRM = 0; read f5 → 0. Set instrRm_i = 111 → rm_o = 000, rmIllegal_o = 0, fsDirty_o = 0.
- **Write, readback and bypass:** write f3 = 0x3F800000; next cycle all three ports addressing f3 read 0x3F800000. During the write cycle, rs2_o = 0x3F800000 with FPU_REG_BYPASS_EN defined, and 0 without it.
- **CSR field masking:** csrOp 01 to 0x003 with 0xFFFF_FFE5 → csrRdata_o of the next read = 0xE5; frm = 111; fflags = 0x05. Then instrRm_i = 111 → rmIllegal_o = 1.
- **Flag accumulation:** fflagsValid_i with fflags_i = 0x01, then with 0x10 → fflags = 0x11. In the same cycle, CSR clear of 0x001 with 0x11 together with fflags_i = 0x04 → fflags = 0x04.
- **Illegal CSR address:** csrAddr_i = 0x004 → csrIllegal_o = 1, csrRdata_o = 0, no state change. csrOp 10 to 0x002 with 0x02 when frm = 0x1 → frm = 0x3.
- **Asynchronous reset mid-operation:** assert reset_i between edges while wrEnable_i is high → all outputs return to reset values before the next edge, and the write is lost.
